id_ex_stage: RTL

Decode-to-execute pipeline stage that sits directly upstream of the ALU. It registers decoded operands and control, then applies EX/MEM and MEM/WB forwarding. It selects the ALU A/B operands and passes the 4-bit ALU opcode through. It also detects load-use hazards and inserts bubbles, and honours a global hold (cache miss) and a flush (branch redirect).

---
 rtl/riscv_pkg.sv | 54 +++++
 rtl/id_ex_stage_if.sv | 70 +++++++
 rtl/fwd_mux.sv | 26 ++
 rtl/id_ex_stage.sv | 96 +++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the decode/execute boundary: widths, ALU opcodes, operand selects.
// Also holds the EX pipeline register layout and the forwarding match helper.
package riscv_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SUB   = 4'b0001,
        ALU_AND   = 4'b0010,
        ALU_OR    = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SLT   = 4'b0101,
        ALU_SLTU  = 4'b0111,
        ALU_SLL   = 4'b1000,
        ALU_SRA   = 4'b1001,
        ALU_SRL   = 4'b1010,
        ALU_PASSB = 4'b1011,
        ALU_TZCNT = 4'b1110
    } alu_op_e;

    localparam logic SRC_A_RS1 = 1'b0;
    localparam logic SRC_A_PC  = 1'b1;
    localparam logic SRC_B_RS2 = 1'b0;
    localparam logic SRC_B_IMM = 1'b1;

    // All-zero is the bubble: valid=0, ADD, no side effects.
    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   rs1_data;
        logic [XLEN-1:0]   rs2_data;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        alu_op_e           alu_ctrl;
        logic              src_a;
        logic              src_b;
        logic              reg_write;
        logic              mem_read;
        logic              mem_write;
        logic              branch;
        logic              jump;
    } ex_regs_t;

    // A producer forwards only if it writes a non-x0 register matching the consumer.
    function automatic logic fwd_hit(input logic wr, input logic [REG_AW-1:0] rd,
                                     input logic [REG_AW-1:0] rs);
        return wr && (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of decode inputs, forward sources and EX outputs for id_ex_stage.
// master drives ID/forward side, slave is the stage itself.
interface id_ex_stage_if;
    import riscv_pkg::*;

    logic              hold_i;
    logic              flush_i;
    logic              id_valid_i;
    logic [XLEN-1:0]   id_pc_i;
    logic [XLEN-1:0]   id_rs1_data_i;
    logic [XLEN-1:0]   id_rs2_data_i;
    logic [XLEN-1:0]   id_imm_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              id_use_rs1_i;
    logic              id_use_rs2_i;
    alu_op_e           id_alu_ctrl_i;
    logic              id_src_a_i;
    logic              id_src_b_i;
    logic              id_reg_write_i;
    logic              id_mem_read_i;
    logic              id_mem_write_i;
    logic              id_branch_i;
    logic              id_jump_i;
    logic [REG_AW-1:0] exm_rd_i;
    logic              exm_reg_write_i;
    logic [XLEN-1:0]   exm_result_i;
    logic [REG_AW-1:0] wb_rd_i;
    logic              wb_reg_write_i;
    logic [XLEN-1:0]   wb_result_i;

    logic              stall_o;
    logic              ex_valid_o;
    logic [XLEN-1:0]   alu_a_o;
    logic [XLEN-1:0]   alu_b_o;
    alu_op_e           alu_ctrl_o;
    logic [XLEN-1:0]   store_data_o;
    logic [XLEN-1:0]   ex_pc_o;
    logic [XLEN-1:0]   ex_imm_o;
    logic [REG_AW-1:0] ex_rd_o;
    logic              ex_reg_write_o;
    logic              ex_mem_read_o;
    logic              ex_mem_write_o;
    logic              ex_branch_o;
    logic              ex_jump_o;

    modport master (
        output hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i, id_alu_ctrl_i,
               id_src_a_i, id_src_b_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
               id_branch_i, id_jump_i, exm_rd_i, exm_reg_write_i, exm_result_i,
               wb_rd_i, wb_reg_write_i, wb_result_i,
        input  stall_o, ex_valid_o, alu_a_o, alu_b_o, alu_ctrl_o, store_data_o, ex_pc_o,
               ex_imm_o, ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
               ex_branch_o, ex_jump_o
    );

    modport slave (
        input  hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_data_i, id_rs2_data_i, id_imm_i,
               id_rs1_i, id_rs2_i, id_rd_i, id_use_rs1_i, id_use_rs2_i, id_alu_ctrl_i,
               id_src_a_i, id_src_b_i, id_reg_write_i, id_mem_read_i, id_mem_write_i,
               id_branch_i, id_jump_i, exm_rd_i, exm_reg_write_i, exm_result_i,
               wb_rd_i, wb_reg_write_i, wb_result_i,
        output stall_o, ex_valid_o, alu_a_o, alu_b_o, alu_ctrl_o, store_data_o, ex_pc_o,
               ex_imm_o, ex_rd_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o,
               ex_branch_o, ex_jump_o
    );

endinterface

// File: rtl/fwd_mux.sv
// Operand forwarding mux: EX/MEM result beats MEM/WB result beats the registered value.
// Purely combinational; x0 is never forwarded.
module fwd_mux
    import riscv_pkg::*;
(
    input  logic [REG_AW-1:0] rs,
    input  logic [XLEN-1:0]   reg_data,
    input  logic [REG_AW-1:0] exm_rd,
    input  logic              exm_reg_write,
    input  logic [XLEN-1:0]   exm_result,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_reg_write,
    input  logic [XLEN-1:0]   wb_result,
    output logic [XLEN-1:0]   data
);

    always_comb begin
        data = reg_data;
        if (fwd_hit(exm_reg_write, exm_rd, rs)) begin
            data = exm_result;
        end else if (fwd_hit(wb_reg_write, wb_rd, rs)) begin
            data = wb_result;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion, hold and flush.
// One cycle ID->EX; ALU operands and stall are combinational from EX regs and forward sources.
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    id_ex_stage_if.slave  bus
);

    ex_regs_t        ex_q;
    ex_regs_t        id_d;
    logic            rs1_hit;
    logic            rs2_hit;
    logic            stall;
    logic [XLEN-1:0] fwd_rs1;
    logic [XLEN-1:0] fwd_rs2;

    always_comb begin
        id_d           = '0;
        id_d.valid     = 1'b1;
        id_d.pc        = bus.id_pc_i;
        id_d.rs1_data  = bus.id_rs1_data_i;
        id_d.rs2_data  = bus.id_rs2_data_i;
        id_d.imm       = bus.id_imm_i;
        id_d.rs1       = bus.id_rs1_i;
        id_d.rs2       = bus.id_rs2_i;
        id_d.rd        = bus.id_rd_i;
        id_d.alu_ctrl  = bus.id_alu_ctrl_i;
        id_d.src_a     = bus.id_src_a_i;
        id_d.src_b     = bus.id_src_b_i;
        id_d.reg_write = bus.id_reg_write_i;
        id_d.mem_read  = bus.id_mem_read_i;
        id_d.mem_write = bus.id_mem_write_i;
        id_d.branch    = bus.id_branch_i;
        id_d.jump      = bus.id_jump_i;
    end

    // A load in EX cannot forward in time; the consumer must wait one cycle.
    assign rs1_hit = bus.id_use_rs1_i && (bus.id_rs1_i == ex_q.rd);
    assign rs2_hit = bus.id_use_rs2_i && (bus.id_rs2_i == ex_q.rd);
    assign stall   = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) && bus.id_valid_i
                     && (rs1_hit || rs2_hit) && !bus.flush_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else if (!bus.hold_i) begin
            if (bus.flush_i || stall || !bus.id_valid_i) begin
                ex_q <= '0;
            end else begin
                ex_q <= id_d;
            end
        end
    end

    fwd_mux u_fwd_rs1 (
        .rs            (ex_q.rs1),
        .reg_data      (ex_q.rs1_data),
        .exm_rd        (bus.exm_rd_i),
        .exm_reg_write (bus.exm_reg_write_i),
        .exm_result    (bus.exm_result_i),
        .wb_rd         (bus.wb_rd_i),
        .wb_reg_write  (bus.wb_reg_write_i),
        .wb_result     (bus.wb_result_i),
        .data          (fwd_rs1)
    );

    fwd_mux u_fwd_rs2 (
        .rs            (ex_q.rs2),
        .reg_data      (ex_q.rs2_data),
        .exm_rd        (bus.exm_rd_i),
        .exm_reg_write (bus.exm_reg_write_i),
        .exm_result    (bus.exm_result_i),
        .wb_rd         (bus.wb_rd_i),
        .wb_reg_write  (bus.wb_reg_write_i),
        .wb_result     (bus.wb_result_i),
        .data          (fwd_rs2)
    );

    assign bus.stall_o        = stall;
    assign bus.ex_valid_o     = ex_q.valid;
    assign bus.alu_a_o        = (ex_q.src_a == SRC_A_PC)  ? ex_q.pc  : fwd_rs1;
    assign bus.alu_b_o        = (ex_q.src_b == SRC_B_IMM) ? ex_q.imm : fwd_rs2;
    assign bus.alu_ctrl_o     = ex_q.alu_ctrl;
    assign bus.store_data_o   = fwd_rs2;
    assign bus.ex_pc_o        = ex_q.pc;
    assign bus.ex_imm_o       = ex_q.imm;
    assign bus.ex_rd_o        = ex_q.rd;
    assign bus.ex_reg_write_o = ex_q.valid & ex_q.reg_write;
    assign bus.ex_mem_read_o  = ex_q.valid & ex_q.mem_read;
    assign bus.ex_mem_write_o = ex_q.valid & ex_q.mem_write;
    assign bus.ex_branch_o    = ex_q.valid & ex_q.branch;
    assign bus.ex_jump_o      = ex_q.valid & ex_q.jump;

endmodule
